// File: rtl/sram_seq.sv
// rtl/sram_seq.sv - record/playback sequencer between 16-bit sample streams and a word SRAM
//
// Purpose: records a stream of ADC samples into consecutive SRAM words and plays
// them back on request to the DAC path. Each SRAM strobe is held ACC_CYCLES cycles.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   start, stop, mode_record  operation control (start samples mode_record; stop wins)
//   sample_in, sample_in_valid      record-side sample stream
//   sample_req                      playback-side request for the next sample
//   sample_out, sample_out_valid    playback-side returned sample
//   sram_addr, sram_read, sram_write, sram_wdata, sram_rdata   SRAM access port
//   busy, done, rec_len, overrun    status
module sram_seq #(
  parameter logic [17:0] MAX_ADDR   = 18'h3FFFF,
  parameter int          ACC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        mode_record,
  input  logic [15:0] sample_in,
  input  logic        sample_in_valid,
  input  logic        sample_req,
  output logic [15:0] sample_out,
  output logic        sample_out_valid,
  output logic [17:0] sram_addr,
  output logic        sram_read,
  output logic        sram_write,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        busy,
  output logic        done,
  output logic [17:0] rec_len,
  output logic        overrun
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REC_WAIT  = 3'd1;
  localparam logic [2:0] REC_WRITE = 3'd2;
  localparam logic [2:0] PLAY_WAIT = 3'd3;
  localparam logic [2:0] PLAY_READ = 3'd4;

  localparam int            CW       = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [17:0]   addr_q, addr_d;
  logic [17:0]   rec_len_q, rec_len_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sov_q, sov_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic          stop_pend_q, stop_pend_d;

  logic acc_last;
  logic end_req;

  assign acc_last = (cnt_q == CNT_LAST);
  // A stop seen during an access, or on its final cycle, ends the operation once the access completes.
  assign end_req  = stop || stop_pend_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rec_len_d   = rec_len_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    sov_d       = 1'b0;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    stop_pend_d = stop_pend_q;

    case (state_q)
      IDLE: begin
        // stop outranks a simultaneous start
        if (start && !stop) begin
          if (mode_record) begin
            addr_d    = '0;
            rec_len_d = '0;
            overrun_d = 1'b0;
            state_d   = REC_WAIT;
          end else if (rec_len_q == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = '0;
            state_d = PLAY_WAIT;
          end
        end
      end

      REC_WAIT: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (sample_in_valid) begin
          wdata_d     = sample_in;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = REC_WRITE;
        end
      end

      REC_WRITE: begin
        // The SRAM is occupied; any sample arriving now is lost.
        if (sample_in_valid) overrun_d = 1'b1;
        if (stop) stop_pend_d = 1'b1;
        if (acc_last) begin
          rec_len_d = addr_q + 18'd1;
          if ((addr_q == MAX_ADDR) || end_req) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 18'd1;
            state_d = REC_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PLAY_WAIT: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (sample_req) begin
          cnt_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = PLAY_READ;
        end
      end

      PLAY_READ: begin
        if (stop) stop_pend_d = 1'b1;
        if (acc_last) begin
          rdata_d = sram_rdata;
          sov_d   = 1'b1;
          if ((addr_q + 18'd1 == rec_len_q) || end_req) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 18'd1;
            state_d = PLAY_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rec_len_q   <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      sov_q       <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rec_len_q   <= rec_len_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      sov_q       <= sov_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Strobes decode straight from the state, so they can never overlap and drop with the state.
  assign sram_write       = (state_q == REC_WRITE);
  assign sram_read        = (state_q == PLAY_READ);
  assign busy             = (state_q != IDLE);
  assign sram_addr        = addr_q;
  assign sram_wdata       = wdata_q;
  assign sample_out       = rdata_q;
  assign sample_out_valid = sov_q;
  assign done             = done_q;
  assign rec_len          = rec_len_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_sram_seq.sv
// tb/tb_sram_seq.sv - scoreboard bench for sram_seq with a transaction-level reference model
module tb_sram_seq;

  localparam int ACC = 2;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  typedef struct packed {
    logic [15:0] data;
    int          cyc;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, mode_record = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_in_valid = 1'b0, sample_req = 1'b0;
  logic [15:0] sram_rdata;
  logic [15:0] sample_out, sram_wdata;
  logic        sample_out_valid, sram_read, sram_write, busy, done, overrun;
  logic [17:0] sram_addr, rec_len;

  logic        start_b = 1'b0;
  logic [15:0] sample_in_b = '0;
  logic        sample_in_valid_b = 1'b0;
  logic [15:0] b_sample_out, b_sram_wdata;
  logic        b_sov, b_sram_read, b_sram_write, b_busy, b_done, b_overrun;
  logic [17:0] b_sram_addr, b_rec_len;

  sram_seq dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_record(mode_record),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid), .sample_req(sample_req),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .sram_addr(sram_addr), .sram_read(sram_read), .sram_write(sram_write),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy), .done(done), .rec_len(rec_len), .overrun(overrun)
  );

  sram_seq #(.MAX_ADDR(18'd3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(1'b0), .mode_record(1'b1),
    .sample_in(sample_in_b), .sample_in_valid(sample_in_valid_b), .sample_req(1'b0),
    .sample_out(b_sample_out), .sample_out_valid(b_sov),
    .sram_addr(b_sram_addr), .sram_read(b_sram_read), .sram_write(b_sram_write),
    .sram_wdata(b_sram_wdata), .sram_rdata(16'h0000),
    .busy(b_busy), .done(b_done), .rec_len(b_rec_len), .overrun(b_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM device model
  logic [15:0] sram_mem [0:255];
  always @(posedge clk) if (sram_write) sram_mem[sram_addr[7:0]] <= sram_wdata;
  assign sram_rdata = sram_mem[sram_addr[7:0]];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the sequencer should hold, in plain terms
  logic [15:0] m_mem [0:63];
  int          m_rec_len = 0;
  bit          m_overrun = 0;

  wr_t exp_wr[$];
  rd_t exp_rd[$];
  int  exp_done[$];

  // Monitor / scoreboard
  int          wr_run = 0, rd_run = 0, rd_strobe_cycles = 0;
  bit          rd_cut = 0, rst_prev = 1;
  logic [17:0] wr_addr0 = '0;
  logic [15:0] wr_data0 = '0, out_prev = '0;

  always @(negedge clk) begin : mon
    wr_t w;
    rd_t r;
    int  dc;
    if (sram_read || sram_write) chk("strobe_excl", int'(sram_read && sram_write), 0);
    if (sram_write) begin
      if (wr_run == 0) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", int'(sram_addr), int'(w.addr));
          chk("wr_data", int'(sram_wdata), int'(w.data));
          chk("wr_cycle", cyc, w.cyc);
        end
        wr_addr0 = sram_addr;
        wr_data0 = sram_wdata;
      end else begin
        chk("wr_addr_stable", int'(sram_addr), int'(wr_addr0));
        chk("wr_data_stable", int'(sram_wdata), int'(wr_data0));
      end
      wr_run++;
    end else if (wr_run != 0) begin
      chk("wr_len", wr_run, ACC);
      wr_run = 0;
    end
    if (sram_read) begin
      rd_run++;
      rd_strobe_cycles++;
      if (rst) rd_cut = 1;
    end else if (rd_run != 0) begin
      if (!rd_cut) chk("rd_len", rd_run, ACC);
      rd_run = 0;
      rd_cut = 0;
    end
    if (sample_out_valid) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        r = exp_rd.pop_front();
        chk("rd_data", int'(sample_out), int'(r.data));
        chk("rd_cycle", cyc, r.cyc);
      end
    end else if (!rst && !rst_prev) begin
      chk("out_hold", int'(sample_out), int'(out_prev));
    end
    if (done) begin
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        dc = exp_done.pop_front();
        chk("done_cycle", cyc, dc);
      end
    end
    out_prev = sample_out;
    rst_prev = rst;
  end

  int   b_wr_cnt = 0, b_done_cnt = 0;
  logic b_prev_wr = 1'b0;
  always @(negedge clk) begin
    if (b_sram_write && !b_prev_wr) begin
      chk("b_wr_addr", int'(b_sram_addr), b_wr_cnt);
      b_wr_cnt++;
    end
    if (b_done) b_done_cnt++;
    b_prev_wr = b_sram_write;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic rec);
    start = 1'b1;
    mode_record = rec;
    tick();
    start = 1'b0;
  endtask

  // stop_kind: 0 stop while waiting, 1 stop during the last write, 2 stop+start together while waiting
  task automatic record_run(input int n, input int stop_kind, input bit busy_start, input bit fixed);
    wr_t w;
    int  c;
    pulse_start(1'b1);
    m_rec_len = 0;
    m_overrun = 0;
    for (int i = 0; i < n; i++) begin
      c = cyc;
      w.addr = 18'(i);
      w.data = fixed ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
      w.cyc  = c + 1;
      sample_in = w.data;
      sample_in_valid = 1'b1;
      exp_wr.push_back(w);
      m_mem[i] = w.data;
      m_rec_len = i + 1;
      tick();
      sample_in_valid = 1'b0;
      if (i == n - 1 && stop_kind == 1) begin
        stop = 1'b1;
        exp_done.push_back(c + 3);
        tick();
        stop = 1'b0;
        tick();
        tick();
      end else begin
        repeat ($urandom_range(2, 4)) tick();
        if (busy_start && i == 0) begin
          start = 1'b1;
          mode_record = 1'b0;
          tick();
          start = 1'b0;
          tick();
        end
      end
    end
    if (n == 0 || stop_kind != 1) begin
      c = cyc;
      stop = 1'b1;
      if (stop_kind == 2) start = 1'b1;
      exp_done.push_back(c + 1);
      tick();
      stop = 1'b0;
      start = 1'b0;
      tick();
    end
    chk("rec_len", int'(rec_len), m_rec_len);
    chk("rec_busy", int'(busy), 0);
    chk("rec_overrun", int'(overrun), int'(m_overrun));
  endtask

  task automatic play_run(input int nreq, input int stop_at, input bit stray);
    int  c;
    bit  active, ending;
    rd_t r;
    c = cyc;
    if (m_rec_len == 0) begin
      exp_done.push_back(c + 1);
      pulse_start(1'b0);
      tick();
      tick();
      chk("play_empty_busy", int'(busy), 0);
      return;
    end
    pulse_start(1'b0);
    active = 1;
    for (int j = 0; j < nreq; j++) begin
      c = cyc;
      sample_req = 1'b1;
      ending = 0;
      if (active) begin
        r.data = m_mem[j];
        r.cyc  = c + 3;
        exp_rd.push_back(r);
        if (j == m_rec_len - 1 || j == stop_at) begin
          exp_done.push_back(c + 3);
          ending = 1;
        end
      end
      tick();
      sample_req = 1'b0;
      if (active && j == stop_at) stop = 1'b1;
      else if (stray) sample_req = 1'b1;
      tick();
      stop = 1'b0;
      sample_req = 1'b0;
      tick();
      repeat ($urandom_range(0, 2)) tick();
      if (ending) active = 0;
    end
    if (active) begin
      c = cyc;
      stop = 1'b1;
      exp_done.push_back(c + 1);
      tick();
      stop = 1'b0;
      tick();
    end
    chk("play_busy", int'(busy), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    int  c, rs, n;
    wr_t w;
    repeat (3) tick();
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_sov", int'(sample_out_valid), 0);
    chk("rst_sram_read", int'(sram_read), 0);
    chk("rst_sram_write", int'(sram_write), 0);
    chk("rst_wdata", int'(sram_wdata), 0);
    chk("rst_addr", int'(sram_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rec_len", int'(rec_len), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick();

    // empty playback
    rs = rd_strobe_cycles;
    play_run(2, -1, 0);
    chk("empty_play_no_read", rd_strobe_cycles - rs, 0);

    // fixed four-sample record, then full and repeated playback
    record_run(4, 0, 1, 1);
    play_run(5, -1, 1);
    play_run(4, 1, 0);
    play_run(1, -1, 0);
    chk("rec_len_persist", int'(rec_len), 4);

    // start+stop together in IDLE: nothing starts
    start = 1'b1; mode_record = 1'b0; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    chk("idle_stop_wins", int'(busy), 0);

    // overrun: second sample lands in the 2nd write cycle and is dropped
    pulse_start(1'b1);
    m_rec_len = 0;
    c = cyc;
    w.addr = 18'd0; w.data = 16'hA5A5; w.cyc = c + 1;
    sample_in = w.data; sample_in_valid = 1'b1;
    exp_wr.push_back(w); m_mem[0] = w.data;
    tick(); sample_in_valid = 1'b0;
    tick();
    sample_in = 16'hDEAD; sample_in_valid = 1'b1;
    tick(); sample_in_valid = 1'b0; m_overrun = 1;
    tick();
    c = cyc;
    w.addr = 18'd1; w.data = 16'h5A5A; w.cyc = c + 1;
    sample_in = w.data; sample_in_valid = 1'b1;
    exp_wr.push_back(w); m_mem[1] = w.data; m_rec_len = 2;
    tick(); sample_in_valid = 1'b0;
    repeat (3) tick();
    c = cyc; stop = 1'b1; exp_done.push_back(c + 1);
    tick(); stop = 1'b0;
    tick();
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_rec_len", int'(rec_len), 2);
    play_run(2, -1, 0);
    chk("ovr_sticky", int'(overrun), 1);

    // stop during a write, stop+start while waiting
    record_run(3, 1, 0, 0);
    play_run(3, -1, 0);
    record_run(2, 2, 0, 0);
    play_run(2, 0, 0);

    // randomized record/playback rounds
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 6);
      record_run(n, $urandom_range(0, 1), 0, 0);
      play_run($urandom_range(1, n + 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1,
               1'($urandom_range(0, 1)));
    end

    // reset in the middle of a read
    record_run(2, 0, 0, 0);
    pulse_start(1'b0);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_rec_len = 0;
    m_overrun = 0;
    chk("mid_rst_read", int'(sram_read), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rec_len", int'(rec_len), 0);
    chk("mid_rst_sov", int'(sample_out_valid), 0);
    tick();
    chk("mid_rst_sov_after", int'(sample_out_valid), 0);
    play_run(1, -1, 0);

    // MAX_ADDR=3 instance with continuous samples
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    sample_in_valid_b = 1'b1;
    repeat (20) begin
      sample_in_b = 16'(cyc);
      tick();
    end
    sample_in_valid_b = 1'b0;
    repeat (3) tick();
    chk("max_writes", b_wr_cnt, 4);
    chk("max_done", b_done_cnt, 1);
    chk("max_rec_len", int'(b_rec_len), 4);
    chk("max_busy", int'(b_busy), 0);

    repeat (6) tick();
    chk("exp_wr_left", exp_wr.size(), 0);
    chk("exp_rd_left", exp_rd.size(), 0);
    chk("exp_done_left", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
